bk_cfg_seq: RTL and testbench
=============================

Name: bk_cfg_seq

Overview:
- Parametrised successor to the single-shot BK register config block.
- Software preloads a table of up to DEPTH (index, value) pairs. On ap_start_pedge the block replays them to the BK core over a Ready/Ack handshake instead of a fixed delay.
- ap_done_o is reported only after every entry has been acknowledged, or after a per-entry timeout.
- Sits between the AXI-lite register bank (reg ports) and the BK core config interface.

Parameters:
- DEPTH, 16, number of table entries; power of two, 2..256.
- DATA_W, 32, width of the index and value fields.
- ACK_BIT, 0, bit of BK_Status_i used as the entry acknowledge.
- TIMEOUT, 50000, maximum cycles to wait in each handshake phase; 0 disables the timeout.
- GAP, 4, idle cycles between entries, with ready low; 0 is allowed.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- ap_start_pedge, in, 1, one-cycle start pulse.
- ap_done_o, out, 1, one-cycle completion pulse.
- ap_busy_o, out, 1, high while the sequence runs.
- tbl_wr_en_i, in, 1, table write strobe.
- tbl_wr_addr_i, in, log2(DEPTH), table write address.
- tbl_wr_index_i, in, DATA_W, index field to store.
- tbl_wr_value_i, in, DATA_W, value field to store.
- cfg_len_i, in, log2(DEPTH)+1, number of entries to send.
- BkpCfg_Ready_o, out, 1, entry valid toward the BK core.
- BkpCfg_DataIndex_o, out, DATA_W, current index.
- BkpCfg_DataValue_o, out, DATA_W, current value.
- BK_Status_i, in, 32, BK core status; bit ACK_BIT is the acknowledge.
- status_o, out, 32, readback word (layout under Behaviour).

Behaviour:
- Clock and reset: all state on posedge clk. Reset is synchronous, active-low, sampled on the edge.
- Reset values: every output 0; FSM in IDLE; pointer 0; sticky flags 0. Table contents are not reset.
- Reset mid-sequence: Ready drops on the next edge and no done pulse is produced.
- Table write timing: tbl_wr_en_i is accepted only in IDLE. Writes while busy are dropped and the table is unchanged.
- Table read timing: synchronous read, 1-cycle latency.
- Length latch: len = min(cfg_len_i, DEPTH), latched on start.
- FSM state IDLE:
  - ap_start_pedge with len>0 -> LOAD; ptr=0; clear done/err flags.
  - ap_start_pedge with len==0 -> DONE.
- FSM state LOAD: issue table read of ptr -> DRIVE.
- FSM state DRIVE:
  - Index and value are registered from the table; Ready=1.
  - Timing from a start pulse at cycle 0: LOAD at cycle 1; Ready, index and value valid at cycle 2.
  - Ack high sampled -> RELEASE. Ack is level-sensitive, so an ack already high is accepted one cycle after entering DRIVE.
- FSM state RELEASE: Ready=0. Index and value hold. Wait for ack low.
  - If ptr==len-1 -> DONE.
  - Else ptr++ -> GAP, or straight to LOAD when GAP==0.
- FSM state GAP: count GAP cycles -> LOAD.
- FSM state DONE: ap_done_o=1 for exactly one cycle; sets done_sticky -> IDLE.
- Timeout:
  - A wait counter counts in DRIVE and in RELEASE, and clears on each state change.
  - When it reaches TIMEOUT-1 and TIMEOUT!=0: set err_sticky, freeze ptr, Ready=0 -> DONE.
  - ap_done_o still pulses on a timeout.
- ap_start_pedge while not IDLE: ignored, with no restart.
- Busy: ap_busy_o = (state != IDLE).
- Start on the reset-release cycle: ignored.
- status_o layout:
  - [0] busy.
  - [1] done_sticky.
  - [2] err_sticky (timeout).
  - [3] reserved, 0.
  - [7:4] FSM state code.
  - [15:8] ptr, zero-extended; on error it holds the failing entry.
  - [31:16] BK_Status_i[15:0], combinational passthrough.
- Width rules: all counters are unsigned. ptr is log2(DEPTH)+1 bits, so len=DEPTH never wraps. The timeout counter is 32 bits.

Decomposition:
- Package bk_cfg_pkg:
  - FSM state encoding: IDLE=0, LOAD=1, DRIVE=2, RELEASE=3, GAP=4, DONE=5.
  - status_o bit-position constants.
  - clog2 helper.
- Sub-module bk_cfg_tbl: simple dual-port DEPTH x 2*DATA_W table with one write port and one synchronous read port. It maps to distributed or block RAM.

Test Plan:
- Normal run: len=3 with entries (0x10,0xA), (0x11,0xB), (0x12,0xC); the BK model acks 5 cycles after Ready and drops ack 2 cycles later. Required: three Ready pulses in order with the matching index/value; ap_done_o is one cycle; status_o[1]=1, [2]=0.
- Zero length: cfg_len_i=0, start. Required: Ready never asserts; ap_done_o pulses 2 cycles after start.
- Timeout: TIMEOUT=100, len=2, ack never asserted. Required: Ready falls after 100 cycles in DRIVE; done pulses; err=1; status_o[15:8]=0.
- Start while busy: second ap_start_pedge during entry 1 of 3. Required: ignored; exactly 3 entries are sent and one done pulse is produced.
- Write while busy: table write to addr 1 during the run. Required: dropped; the next run still sends the original entry-1 value.
- Reset mid-sequence: rst_n low for 1 cycle while in DRIVE on entry 2. Required: all outputs 0 next cycle; no done pulse; a restart sends from entry 0.

Source files
------------

// File: rtl/bk_cfg_pkg.sv
// -----------------------------------------------------------------------------
// bk_cfg_pkg
// Shared definitions for the BK configuration sequencer:
//   - state_e : FSM state encoding, also exported on status_o[7:4]
//   - STAT_*  : bit positions / widths of the status_o readback word
//   - clog2() : constant ceil(log2) helper used for port and counter widths
// -----------------------------------------------------------------------------
package bk_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_DRIVE   = 4'd2,
    S_RELEASE = 4'd3,
    S_GAP     = 4'd4,
    S_DONE    = 4'd5
  } state_e;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_ERR       = 2;
  localparam int STAT_STATE_LSB = 4;
  localparam int STAT_STATE_W   = 4;
  localparam int STAT_PTR_LSB   = 8;
  localparam int STAT_PTR_W     = 8;
  localparam int STAT_BK_LSB    = 16;
  localparam int STAT_BK_W      = 16;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/bk_cfg_tbl.sv
// -----------------------------------------------------------------------------
// bk_cfg_tbl
// Simple dual-port DEPTH x WIDTH table: one write port, one synchronous read
// port with one cycle of latency. Written so it maps onto distributed or
// block RAM.
//   clk      : system clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read enable; rd_data updates on the next edge only when set
//   rd_addr  : read address
//   rd_data  : registered read data (holds between reads)
// -----------------------------------------------------------------------------
module bk_cfg_tbl
  import bk_cfg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  input  logic [clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]          rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and read register have no reset; a reset would stop the
  // tools from mapping this onto RAM. The sequencer masks rd_data until the
  // first read after reset, so the unknown initial value is never visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/bk_cfg_seq.sv
// -----------------------------------------------------------------------------
// bk_cfg_seq
// Replays a software-preloaded table of (index, value) pairs to the BK core
// over a Ready/Ack handshake, one entry at a time, then pulses ap_done_o.
// Each handshake phase is guarded by a cycle timeout.
//   clk, rst_n          : clock, synchronous active-low reset
//   ap_start_pedge      : one-cycle start pulse (ignored unless idle)
//   ap_done_o           : one-cycle completion pulse (also on timeout)
//   ap_busy_o           : high while the sequence runs
//   tbl_wr_*            : table write port, accepted only while idle
//   cfg_len_i           : entries to send, clamped to DEPTH at start
//   BkpCfg_Ready_o      : entry valid toward the BK core
//   BkpCfg_DataIndex_o  : index of the current entry
//   BkpCfg_DataValue_o  : value of the current entry
//   BK_Status_i         : BK core status; bit ACK_BIT is the acknowledge
//   status_o            : {BK_Status_i[15:0], ptr, state, 0, err, done, busy}
// -----------------------------------------------------------------------------
module bk_cfg_seq
  import bk_cfg_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter int          DATA_W  = 32,
  parameter int          ACK_BIT = 0,
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned GAP     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ap_start_pedge,
  output logic                      ap_done_o,
  output logic                      ap_busy_o,
  input  logic                      tbl_wr_en_i,
  input  logic [clog2(DEPTH)-1:0]   tbl_wr_addr_i,
  input  logic [DATA_W-1:0]         tbl_wr_index_i,
  input  logic [DATA_W-1:0]         tbl_wr_value_i,
  input  logic [clog2(DEPTH):0]     cfg_len_i,
  output logic                      BkpCfg_Ready_o,
  output logic [DATA_W-1:0]         BkpCfg_DataIndex_o,
  output logic [DATA_W-1:0]         BkpCfg_DataValue_o,
  input  logic [31:0]               BK_Status_i,
  output logic [31:0]               status_o
);

  localparam int AW = clog2(DEPTH);
  // One extra bit so that a length of exactly DEPTH is representable.
  localparam int CW = AW + 1;

  state_e            state;
  logic [CW-1:0]     ptr;
  logic [CW-1:0]     len;
  logic [31:0]       wait_cnt;
  logic [31:0]       gap_cnt;
  logic              ready_q;
  logic              done_q;
  logic              done_sticky;
  logic              err_sticky;
  logic              data_vld;
  logic              armed;

  logic              ack;
  logic [CW-1:0]     len_clamped;
  logic              last_entry;
  logic              timeout_hit;
  logic              gap_last;
  logic [2*DATA_W-1:0] rd_data;

  assign ack         = BK_Status_i[ACK_BIT];
  assign len_clamped = (cfg_len_i > CW'(DEPTH)) ? CW'(DEPTH) : cfg_len_i;
  assign last_entry  = (ptr == len - CW'(1));
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TIMEOUT - 1);
  assign gap_last    = (gap_cnt == GAP - 1);

  // Writes are only honoured while idle so the table cannot change under a
  // running sequence; the read is issued only from LOAD, so read and write
  // never collide on the same address.
  bk_cfg_tbl #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_tbl (
    .clk     (clk),
    .wr_en   (tbl_wr_en_i && (state == S_IDLE)),
    .wr_addr (tbl_wr_addr_i),
    .wr_data ({tbl_wr_index_i, tbl_wr_value_i}),
    .rd_en   (state == S_LOAD),
    .rd_addr (ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  // NOTE: all sequential state uses non-blocking assignments so every branch
  // below reads the pre-edge value of state, ptr and the counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      len         <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      done_sticky <= 1'b0;
      err_sticky  <= 1'b0;
      data_vld    <= 1'b0;
      armed       <= 1'b0;
    end else begin
      // armed blocks a start presented on the first edge out of reset.
      armed  <= 1'b1;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ap_start_pedge && armed) begin
            ptr         <= '0;
            len         <= len_clamped;
            done_sticky <= 1'b0;
            err_sticky  <= 1'b0;
            state       <= (len_clamped == '0) ? S_DONE : S_LOAD;
          end
        end

        S_LOAD: begin
          // Table read lands on this edge together with Ready.
          ready_q  <= 1'b1;
          data_vld <= 1'b1;
          wait_cnt <= '0;
          state    <= S_DRIVE;
        end

        S_DRIVE: begin
          if (ack) begin
            ready_q  <= 1'b0;
            wait_cnt <= '0;
            state    <= S_RELEASE;
          end else if (timeout_hit) begin
            ready_q    <= 1'b0;
            err_sticky <= 1'b1;
            wait_cnt   <= '0;
            state      <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        S_RELEASE: begin
          if (!ack) begin
            wait_cnt <= '0;
            if (last_entry) begin
              state <= S_DONE;
            end else begin
              ptr     <= ptr + CW'(1);
              gap_cnt <= '0;
              state   <= (GAP == 0) ? S_LOAD : S_GAP;
            end
          end else if (timeout_hit) begin
            err_sticky <= 1'b1;
            wait_cnt   <= '0;
            state      <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        S_GAP: begin
          if (gap_last) begin
            state <= S_LOAD;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end

        S_DONE: begin
          done_q      <= 1'b1;
          done_sticky <= 1'b1;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign ap_done_o      = done_q;
  assign ap_busy_o      = (state != S_IDLE);
  assign BkpCfg_Ready_o = ready_q;

  // The read register has no reset; hold the data outputs at zero until the
  // first entry has actually been fetched.
  assign BkpCfg_DataIndex_o = data_vld ? rd_data[2*DATA_W-1:DATA_W] : '0;
  assign BkpCfg_DataValue_o = data_vld ? rd_data[DATA_W-1:0]        : '0;

  // NOTE: every bit is given a default first so this block cannot infer a latch.
  always_comb begin
    status_o                                 = '0;
    status_o[STAT_BUSY]                      = ap_busy_o;
    status_o[STAT_DONE]                      = done_sticky;
    status_o[STAT_ERR]                       = err_sticky;
    status_o[STAT_STATE_LSB +: STAT_STATE_W] = state;
    status_o[STAT_PTR_LSB +: STAT_PTR_W]     = STAT_PTR_W'(ptr);
    status_o[STAT_BK_LSB +: STAT_BK_W]       = BK_Status_i[STAT_BK_W-1:0];
  end

endmodule

// File: tb/tb_bk_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_bk_cfg_seq
// Self-checking bench for bk_cfg_seq (DEPTH=16, DATA_W=32, TIMEOUT=100, GAP=4).
// A BK-core model acks each Ready after a fixed delay; a monitor pops the
// expected entry from a scoreboard queue on every Ready rising edge. Whole
// runs are described by a vector table; cycle-exact corners are hand-written.
// -----------------------------------------------------------------------------
module tb_bk_cfg_seq;

  localparam int DEPTH    = 16;
  localparam int DATA_W   = 32;
  localparam int ACK_DLY  = 5;
  localparam int ACK_HOLD = 2;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] val;
  } ent_t;

  typedef struct {
    int len;
    bit ack;
    int sent;
    bit err;
    int ptr;
    int hi;
  } run_vec_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        tbl_wr_en;
  logic [3:0]  tbl_wr_addr;
  logic [31:0] tbl_wr_index;
  logic [31:0] tbl_wr_value;
  logic [4:0]  cfg_len;
  logic        bk_ack;
  logic [15:0] bk_hi;
  logic [31:0] bk_status;

  logic        ap_done_o;
  logic        ap_busy_o;
  logic        BkpCfg_Ready_o;
  logic [31:0] BkpCfg_DataIndex_o;
  logic [31:0] BkpCfg_DataValue_o;
  logic [31:0] status_o;

  int   n_cmp;
  int   n_err;
  int   rise_cnt;
  int   done_cnt;
  int   ready_hi;
  bit   ready_prev;
  bit   ack_on;
  bit   in_hs;
  int   hs_cnt;
  ent_t exp_e;
  ent_t shadow [DEPTH];
  ent_t sb_q [$];
  run_vec_t runs [5];

  assign bk_status = {16'h0000, bk_hi[15:1], bk_ack};

  bk_cfg_seq #(
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W),
    .ACK_BIT (0),
    .TIMEOUT (100),
    .GAP     (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ap_start_pedge     (start),
    .ap_done_o          (ap_done_o),
    .ap_busy_o          (ap_busy_o),
    .tbl_wr_en_i        (tbl_wr_en),
    .tbl_wr_addr_i      (tbl_wr_addr),
    .tbl_wr_index_i     (tbl_wr_index),
    .tbl_wr_value_i     (tbl_wr_value),
    .cfg_len_i          (cfg_len),
    .BkpCfg_Ready_o     (BkpCfg_Ready_o),
    .BkpCfg_DataIndex_o (BkpCfg_DataIndex_o),
    .BkpCfg_DataValue_o (BkpCfg_DataValue_o),
    .BK_Status_i        (bk_status),
    .status_o           (status_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // BK core model: ack ACK_DLY cycles after seeing Ready, hold ACK_HOLD cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_hs  = 1'b0;
      hs_cnt = 0;
      bk_ack = 1'b0;
    end else if (!in_hs) begin
      if (BkpCfg_Ready_o && ack_on) begin
        in_hs  = 1'b1;
        hs_cnt = 1;
      end
    end else begin
      hs_cnt++;
      if (hs_cnt == ACK_DLY) bk_ack = 1'b1;
      if (hs_cnt == ACK_DLY + ACK_HOLD) begin
        bk_ack = 1'b0;
        in_hs  = 1'b0;
      end
    end
  end

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (BkpCfg_Ready_o) ready_hi++;
      if (ap_done_o) done_cnt++;
      if (BkpCfg_Ready_o && !ready_prev) begin
        rise_cnt++;
        check("sb_entry_expected", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) begin
          exp_e = sb_q.pop_front();
          check($sformatf("entry%0d_index", rise_cnt - 1), 64'(BkpCfg_DataIndex_o), 64'(exp_e.idx));
          check($sformatf("entry%0d_value", rise_cnt - 1), 64'(BkpCfg_DataValue_o), 64'(exp_e.val));
        end
      end
    end
    ready_prev = BkpCfg_Ready_o;
  end

  task automatic tbl_write(input int addr, input logic [31:0] idx, input logic [31:0] val);
    tbl_wr_en    = 1'b1;
    tbl_wr_addr  = 4'(addr);
    tbl_wr_index = idx;
    tbl_wr_value = val;
    @(negedge clk);
    tbl_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_counts();
    rise_cnt = 0;
    done_cnt = 0;
    ready_hi = 0;
  endtask

  task automatic push_entries(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(shadow[i]);
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (ap_done_o) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rise(input int n, input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rise_cnt >= n) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_run(input string tag, input run_vec_t v);
    bit seen;
    ack_on = v.ack;
    clear_counts();
    push_entries(v.sent);
    cfg_len = 5'(v.len);
    pulse_start();
    wait_done(2000, seen);
    check({tag, "_done_seen"}, 64'(seen), 64'(1));
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
    check({tag, "_entries_sent"}, 64'(rise_cnt), 64'(v.sent));
    check({tag, "_ready_cycles"}, 64'(ready_hi), 64'(v.hi));
    check({tag, "_sb_drained"}, 64'(sb_q.size()), 64'(0));
    check({tag, "_done_sticky"}, 64'(status_o[1]), 64'(1));
    check({tag, "_err_sticky"}, 64'(status_o[2]), 64'(v.err));
    check({tag, "_ptr"}, 64'(status_o[15:8]), 64'(v.ptr));
    check({tag, "_idle"}, 64'(ap_busy_o), 64'(0));
    sb_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    n_cmp = 0; n_err = 0;
    clear_counts();
    rst_n = 1'b0; start = 1'b0; tbl_wr_en = 1'b0;
    tbl_wr_addr = '0; tbl_wr_index = '0; tbl_wr_value = '0;
    cfg_len = '0; bk_hi = 16'hC3A4; ack_on = 1'b1;
    ready_prev = 1'b0;

    // {len, ack, entries sent, err, final ptr, Ready-high cycles}
    runs[0] = '{len: 3,  ack: 1'b1, sent: 3,  err: 1'b0, ptr: 2,  hi: 3 * ACK_DLY};
    runs[1] = '{len: 1,  ack: 1'b1, sent: 1,  err: 1'b0, ptr: 0,  hi: ACK_DLY};
    runs[2] = '{len: 20, ack: 1'b1, sent: 16, err: 1'b0, ptr: 15, hi: 16 * ACK_DLY};
    runs[3] = '{len: 2,  ack: 1'b0, sent: 1,  err: 1'b1, ptr: 0,  hi: 100};
    runs[4] = '{len: 0,  ack: 1'b1, sent: 0,  err: 1'b0, ptr: 0,  hi: 0};

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(BkpCfg_Ready_o), 64'(0));
    check("rst_done", 64'(ap_done_o), 64'(0));
    check("rst_busy", 64'(ap_busy_o), 64'(0));
    check("rst_index", 64'(BkpCfg_DataIndex_o), 64'(0));
    check("rst_value", 64'(BkpCfg_DataValue_o), 64'(0));
    check("rst_status_lo", 64'(status_o[15:0]), 64'(0));
    check("status_passthru", 64'(status_o[31:16]), 64'({bk_hi[15:1], bk_ack}));

    // Start presented on the reset-release edge must be ignored.
    cfg_len = 5'd3;
    rst_n = 1'b1;
    pulse_start();
    check("start_at_release_ignored", 64'(ap_busy_o), 64'(0));
    repeat (2) @(negedge clk);
    check("start_at_release_no_ready", 64'(BkpCfg_Ready_o), 64'(0));

    for (int i = 0; i < DEPTH; i++) begin
      shadow[i].idx = 32'h10 + 32'(i);
      shadow[i].val = 32'hA + 32'(i);
      tbl_write(i, shadow[i].idx, shadow[i].val);
    end

    // Normal run with cycle-exact start timing.
    ack_on = 1'b1;
    clear_counts();
    push_entries(3);
    cfg_len = 5'd3;
    pulse_start();
    check("t_c1_state_load", 64'(status_o[7:4]), 64'(1));
    check("t_c1_ready_low", 64'(BkpCfg_Ready_o), 64'(0));
    @(negedge clk);
    check("t_c2_ready", 64'(BkpCfg_Ready_o), 64'(1));
    check("t_c2_index", 64'(BkpCfg_DataIndex_o), 64'(32'h10));
    check("t_c2_value", 64'(BkpCfg_DataValue_o), 64'(32'hA));
    check("t_c2_state_drive", 64'(status_o[7:4]), 64'(2));
    wait_done(500, seen);
    check("t_done_seen", 64'(seen), 64'(1));
    @(negedge clk);
    check("t_done_one_cycle", 64'(ap_done_o), 64'(0));
    check("t_done_sticky", 64'(status_o[1]), 64'(1));
    check("t_err_sticky", 64'(status_o[2]), 64'(0));
    check("t_entries", 64'(rise_cnt), 64'(3));

    for (int k = 0; k < 5; k++) begin
      do_run($sformatf("run%0d", k), runs[k]);
    end

    // Zero length: done two cycles after start, Ready never asserted.
    clear_counts();
    cfg_len = 5'd0;
    pulse_start();
    check("z_c1_done_low", 64'(ap_done_o), 64'(0));
    check("z_c1_state_done", 64'(status_o[7:4]), 64'(5));
    @(negedge clk);
    check("z_c2_done", 64'(ap_done_o), 64'(1));
    check("z_c2_busy", 64'(ap_busy_o), 64'(0));
    @(negedge clk);
    check("z_c3_done_low", 64'(ap_done_o), 64'(0));
    check("z_no_ready", 64'(rise_cnt), 64'(0));

    // Start while busy (during entry 1 of 3) is ignored.
    ack_on = 1'b1;
    clear_counts();
    push_entries(3);
    cfg_len = 5'd3;
    pulse_start();
    wait_rise(2, 200, seen);
    check("sb_reached_entry1", 64'(seen), 64'(1));
    pulse_start();
    wait_done(500, seen);
    check("sb_done_seen", 64'(seen), 64'(1));
    repeat (10) @(negedge clk);
    check("sb_entries", 64'(rise_cnt), 64'(3));
    check("sb_done_pulses", 64'(done_cnt), 64'(1));
    check("sb_idle", 64'(ap_busy_o), 64'(0));
    sb_q.delete();

    // Write while busy is dropped; the next run sends the original entry 1.
    clear_counts();
    push_entries(3);
    pulse_start();
    repeat (3) @(negedge clk);
    tbl_write(1, 32'hDEAD_0001, 32'hBEEF_0001);
    wait_done(500, seen);
    check("wb_done_seen", 64'(seen), 64'(1));
    sb_q.delete();
    @(negedge clk);
    do_run("wb_rerun", runs[0]);

    // Reset while in DRIVE on entry 2.
    clear_counts();
    push_entries(3);
    pulse_start();
    wait_rise(3, 200, seen);
    check("mr_reached_entry2", 64'(seen), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_ready", 64'(BkpCfg_Ready_o), 64'(0));
    check("mr_done", 64'(ap_done_o), 64'(0));
    check("mr_busy", 64'(ap_busy_o), 64'(0));
    check("mr_index", 64'(BkpCfg_DataIndex_o), 64'(0));
    check("mr_value", 64'(BkpCfg_DataValue_o), 64'(0));
    check("mr_status_lo", 64'(status_o[15:0]), 64'(0));
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (20) @(negedge clk);
    check("mr_no_done", 64'(done_cnt), 64'(0));
    sb_q.delete();
    do_run("mr_restart", runs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
